// File: rtl/bus6502_pkg.sv
// bus6502_pkg: shared constants and types for the 6502 bus responder.
//   - Hardware vector addresses (NMI, reset, IRQ), low/high byte each.
//   - State encoding for the read wait-state FSM.
package bus6502_pkg;

  localparam logic [15:0] VEC_NMI_LO   = 16'hFFFA;
  localparam logic [15:0] VEC_NMI_HI   = 16'hFFFB;
  localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;
  localparam logic [15:0] VEC_IRQ_LO   = 16'hFFFE;
  localparam logic [15:0] VEC_IRQ_HI   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wait_state_e;

endpackage

// File: rtl/bus_responder_6502_interrupt_timer.sv
// interrupt_timer: free-running periodic NMI generator.
//   Ports:
//     i_clk   - clock, rising edge
//     i_reset - synchronous active-high reset
//     o_nmi   - active-low NMI, low for NMI_PULSE clocks out of every NMI_PERIOD
//   NMI_PERIOD = 0 disables the generator (o_nmi held high).
module interrupt_timer #(
  parameter int NMI_PERIOD = 0,
  parameter int NMI_PULSE  = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_nmi
);

  localparam int CW = (NMI_PERIOD > 1) ? $clog2(NMI_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NMI_PERIOD - 1);
  localparam logic [CW-1:0] PULSE_END  = CW'(NMI_PULSE);

  logic [CW-1:0] r_cnt;
  logic          r_nmi;

  // Period counter; nmi is registered from the count so the first low
  // pulse appears in the cycle after reset is released.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_nmi <= 1'b1;
    end else if (NMI_PERIOD == 0) begin
      r_cnt <= '0;
      r_nmi <= 1'b1;
    end else begin
      r_nmi <= !(r_cnt < PULSE_END);
      if (r_cnt == LAST_COUNT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_nmi = r_nmi;

endmodule

// File: rtl/bus_responder_6502.sv
// bus_responder_6502: bus-side memory and stimulus model for a 6502 core.
//   Ports:
//     clock0, reset          - clock and synchronous active-high reset
//     address, readNotWrite  - CPU address and cycle direction
//     dataIn                 - CPU write data
//     dataOut, dataOutEnable - read data and bus-drive enable
//     ready                  - CPU ready (low inserts wait states on reads)
//     irq, nmi               - active-low interrupt outputs
//     irqRequest             - one-cycle pulse setting the IRQ latch
//     loadValid/Address/Data - RAM preload port (works during reset)
//     writeCount             - wrapping count of committed CPU writes
//   RAM is mirrored across the address space; FFFC/FFFD return RESET_VECTOR.
module bus_responder_6502
  import bus6502_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 16,
  parameter int          DATA_WIDTH      = 8,
  parameter int          MEM_DEPTH_LOG2  = 12,
  parameter logic [15:0] RESET_VECTOR    = 16'h0200,
  parameter int          WAIT_STATES     = 0,
  parameter int          NMI_PERIOD      = 0,
  parameter int          NMI_PULSE       = 2,
  parameter logic [15:0] IRQ_ACK_ADDRESS = 16'hD000
) (
  input  logic                      clock0,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic                      readNotWrite,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  output logic [DATA_WIDTH-1:0]     dataOut,
  output logic                      dataOutEnable,
  output logic                      ready,
  output logic                      irq,
  output logic                      nmi,
  input  logic                      irqRequest,
  input  logic                      loadValid,
  input  logic [MEM_DEPTH_LOG2-1:0] loadAddress,
  input  logic [DATA_WIDTH-1:0]     loadData,
  output logic [15:0]               writeCount
);

  localparam int          MEM_WORDS = 2 ** MEM_DEPTH_LOG2;
  localparam logic [15:0] RV        = RESET_VECTOR;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  logic [DATA_WIDTH-1:0]     r_mem [0:MEM_WORDS-1];
  wait_state_e               r_state;
  logic [3:0]                r_wait_cnt;
  logic                      r_ready;
  logic [ADDR_WIDTH:0]       r_prev;
  logic                      r_first;
  logic                      r_irq_latch;
  logic [15:0]               r_write_count;

  logic                      w_vec_lo;
  logic                      w_vec_hi;
  logic                      w_vector_hit;
  logic [MEM_DEPTH_LOG2-1:0] w_ram_idx;
  logic                      w_cpu_write;
  logic                      w_ack_hit;
  logic                      w_new_read;

  assign w_vec_lo     = (address == ADDR_WIDTH'(VEC_RESET_LO));
  assign w_vec_hi     = (address == ADDR_WIDTH'(VEC_RESET_HI));
  assign w_vector_hit = w_vec_lo | w_vec_hi;
  assign w_ram_idx    = address[MEM_DEPTH_LOG2-1:0];
  assign w_cpu_write  = !reset && !readNotWrite;
  assign w_ack_hit    = (address == ADDR_WIDTH'(IRQ_ACK_ADDRESS));
  // A read is "new" when the bus changed since last cycle, or right after reset.
  assign w_new_read   = readNotWrite && (r_first || ({address, readNotWrite} != r_prev));

  // Read data mux: reset vector ROM overrides the mirrored RAM.
  always_comb begin
    dataOut = '0;
    if (w_vec_lo) begin
      dataOut = DATA_WIDTH'(RV[7:0]);
    end else if (w_vec_hi) begin
      dataOut = DATA_WIDTH'(RV[15:8]);
    end else begin
      dataOut = r_mem[w_ram_idx];
    end
  end

  assign dataOutEnable = readNotWrite && r_ready && !reset;
  assign ready         = r_ready;
  assign irq           = ~r_irq_latch;
  assign writeCount    = r_write_count;

  // RAM write port; a preload to the same index as a CPU write wins. Not reset.
  always_ff @(posedge clock0) begin
    if (loadValid) begin
      r_mem[loadAddress] <= loadData;
    end
    if (w_cpu_write && !w_vector_hit && !(loadValid && (loadAddress == w_ram_idx))) begin
      r_mem[w_ram_idx] <= dataIn;
    end
  end

  // Previous-bus tracking used by new-read detection.
  always_ff @(posedge clock0) begin
    if (reset) begin
      r_first <= 1'b1;
      r_prev  <= '0;
    end else begin
      r_first <= 1'b0;
      r_prev  <= {address, readNotWrite};
    end
  end

  // Wait-state FSM with registered ready.
  always_ff @(posedge clock0) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_ready    <= 1'b1;
    end else if (WAIT_STATES == 0) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_new_read) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WAIT_LOAD;
            r_ready    <= 1'b0;
          end else begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!readNotWrite) begin
            // Bus turned into a write: abandon the pending read.
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
          end else if (w_new_read) begin
            // Address moved mid-wait: restart the count for the new address.
            r_wait_cnt <= WAIT_LOAD;
            r_ready    <= 1'b0;
          end else if (r_wait_cnt == 4'd0) begin
            r_state    <= ST_ACK;
            r_ready    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            r_ready    <= 1'b0;
          end
        end
        ST_ACK: begin
          // A fresh read arriving in ACK must not be lost on the way to IDLE.
          if (w_new_read) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WAIT_LOAD;
            r_ready    <= 1'b0;
          end else begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 4'd0;
          r_ready    <= 1'b1;
        end
      endcase
    end
  end

  // IRQ latch: request has priority over a simultaneous acknowledge write.
  always_ff @(posedge clock0) begin
    if (reset) begin
      r_irq_latch <= 1'b0;
    end else if (irqRequest) begin
      r_irq_latch <= 1'b1;
    end else if (w_cpu_write && w_ack_hit) begin
      r_irq_latch <= 1'b0;
    end else begin
      r_irq_latch <= r_irq_latch;
    end
  end

  // Committed-write counter, including ignored vector writes.
  always_ff @(posedge clock0) begin
    if (reset) begin
      r_write_count <= 16'd0;
    end else if (w_cpu_write) begin
      r_write_count <= r_write_count + 16'd1;
    end else begin
      r_write_count <= r_write_count;
    end
  end

  interrupt_timer #(
    .NMI_PERIOD (NMI_PERIOD),
    .NMI_PULSE  (NMI_PULSE)
  ) u_interrupt_timer (
    .i_clk   (clock0),
    .i_reset (reset),
    .o_nmi   (nmi)
  );

endmodule

// File: tb/tb_bus_responder_6502.sv
// Directed testbench for bus_responder_6502. Three instances share the
// input bus: a (defaults), w (3 wait states, NMI 10/2), r (5 wait states, NMI 10/2).
module tb_bus_responder_6502;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        rnw;
  logic [7:0]  din;
  logic        irq_req;
  logic        load_valid;
  logic [11:0] load_addr;
  logic [7:0]  load_data;

  logic [7:0]  a_dout, w_dout, r_dout;
  logic        a_doe, w_doe, r_doe;
  logic        a_ready, w_ready, r_ready;
  logic        a_irq, w_irq, r_irq;
  logic        a_nmi, w_nmi, r_nmi;
  logic [15:0] a_wc, w_wc, r_wc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_responder_6502 dut_a (
    .clock0(clk), .reset(reset), .address(addr), .readNotWrite(rnw), .dataIn(din),
    .dataOut(a_dout), .dataOutEnable(a_doe), .ready(a_ready), .irq(a_irq), .nmi(a_nmi),
    .irqRequest(irq_req), .loadValid(load_valid), .loadAddress(load_addr),
    .loadData(load_data), .writeCount(a_wc)
  );

  bus_responder_6502 #(.WAIT_STATES(3), .NMI_PERIOD(10), .NMI_PULSE(2)) dut_w (
    .clock0(clk), .reset(reset), .address(addr), .readNotWrite(rnw), .dataIn(din),
    .dataOut(w_dout), .dataOutEnable(w_doe), .ready(w_ready), .irq(w_irq), .nmi(w_nmi),
    .irqRequest(irq_req), .loadValid(load_valid), .loadAddress(load_addr),
    .loadData(load_data), .writeCount(w_wc)
  );

  bus_responder_6502 #(.WAIT_STATES(5), .NMI_PERIOD(10), .NMI_PULSE(2)) dut_r (
    .clock0(clk), .reset(reset), .address(addr), .readNotWrite(rnw), .dataIn(din),
    .dataOut(r_dout), .dataOutEnable(r_doe), .ready(r_ready), .irq(r_irq), .nmi(r_nmi),
    .irqRequest(irq_req), .loadValid(load_valid), .loadAddress(load_addr),
    .loadData(load_data), .writeCount(r_wc)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus and checks.
  initial begin
    logic exp_nmi;
    reset = 1'b1; addr = 16'h0000; rnw = 1'b1; din = 8'h00; irq_req = 1'b0;
    load_valid = 1'b0; load_addr = 12'h000; load_data = 8'h00;
    step();
    step();

    // Preloads during reset
    load_valid = 1'b1; load_addr = 12'h200; load_data = 8'hA9;
    #1;
    check_val("doe_in_reset", {31'd0, a_doe}, 32'd0);
    step();
    load_addr = 12'hFFC; load_data = 8'h5A;
    step();
    load_valid = 1'b0;
    #1;
    check_val("rst_ready", {31'd0, a_ready}, 32'd1);
    check_val("rst_irq", {31'd0, a_irq}, 32'd1);
    check_val("rst_nmi", {31'd0, w_nmi}, 32'd1);
    check_val("rst_wc", {16'd0, a_wc}, 32'd0);
    check_val("rst_w_ready", {31'd0, w_ready}, 32'd1);

    // Vector read and mirroring
    reset = 1'b0; addr = 16'hFFFC;
    #1;
    check_val("vec_lo", {24'd0, a_dout}, 32'h00);
    check_val("vec_doe", {31'd0, a_doe}, 32'd1);
    check_val("vec_ready", {31'd0, a_ready}, 32'd1);
    step();
    addr = 16'hFFFD;
    #1;
    check_val("vec_hi", {24'd0, a_dout}, 32'h02);
    check_val("vec_hi_ready", {31'd0, a_ready}, 32'd1);
    step();
    addr = 16'h0200;
    #1;
    check_val("ram_0200", {24'd0, a_dout}, 32'hA9);
    step();
    addr = 16'h1200;
    #1;
    check_val("mirror_1200", {24'd0, a_dout}, 32'hA9);
    repeat (6) step();

    // Wait states on dut_w: exactly three low cycles, then ACK, then IDLE
    addr = 16'h0300;
    #1;
    check_val("w_idle_ready", {31'd0, w_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("w_wait_ready", {31'd0, w_ready}, 32'd0);
      check_val("w_wait_doe", {31'd0, w_doe}, 32'd0);
    end
    step();
    check_val("w_ack_ready", {31'd0, w_ready}, 32'd1);
    check_val("w_ack_doe", {31'd0, w_doe}, 32'd1);
    step();
    check_val("w_idle2_ready", {31'd0, w_ready}, 32'd1);

    // Write 55 to 0300: no wait, later read returns it
    rnw = 1'b0; din = 8'h55;
    #1;
    check_val("wr_ready", {31'd0, w_ready}, 32'd1);
    step();
    check_val("wr_ready2", {31'd0, w_ready}, 32'd1);
    rnw = 1'b1;
    #1;
    check_val("rd_55_a", {24'd0, a_dout}, 32'h55);
    check_val("rd_55_w", {24'd0, w_dout}, 32'h55);
    check_val("wc_1", {16'd0, a_wc}, 32'd1);

    // Vector write protection and write counter
    step();
    rnw = 1'b0; addr = 16'hFFFC; din = 8'h77;
    step();
    addr = 16'h0010; din = 8'h11;
    step();
    rnw = 1'b1; addr = 16'hFFFC;
    #1;
    check_val("vec_protect", {24'd0, a_dout}, 32'h00);
    step();
    addr = 16'h0FFC;
    #1;
    check_val("ram_under_vec", {24'd0, a_dout}, 32'h5A);
    step();
    addr = 16'h0010;
    #1;
    check_val("rd_0010", {24'd0, a_dout}, 32'h11);
    check_val("wc_3", {16'd0, a_wc}, 32'd3);

    // IRQ handshake
    step();
    irq_req = 1'b1;
    #1;
    check_val("irq_before", {31'd0, a_irq}, 32'd1);
    step();
    irq_req = 1'b0;
    #1;
    check_val("irq_set", {31'd0, a_irq}, 32'd0);
    rnw = 1'b0; addr = 16'hD000; irq_req = 1'b1;
    step();
    irq_req = 1'b0; rnw = 1'b1; addr = 16'h0000;
    #1;
    check_val("irq_set_wins", {31'd0, a_irq}, 32'd0);
    step();
    rnw = 1'b0; addr = 16'hD000;
    step();
    rnw = 1'b1;
    #1;
    check_val("irq_ack", {31'd0, a_irq}, 32'd1);
    check_val("wc_5", {16'd0, a_wc}, 32'd5);

    // Preload beats a same-index CPU write
    rnw = 1'b0; addr = 16'h0010; din = 8'hDD;
    load_valid = 1'b1; load_addr = 12'h010; load_data = 8'hCC;
    step();
    load_valid = 1'b0; rnw = 1'b1;
    #1;
    check_val("load_wins", {24'd0, a_dout}, 32'hCC);
    check_val("wc_6", {16'd0, a_wc}, 32'd6);

    // NMI timing: low on cycles 1-2 of every 10 after release
    reset = 1'b1; addr = 16'h0000;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      exp_nmi = !((k >= 1) && (((k - 1) % 10) < 2));
      check_val("nmi_wave", {31'd0, w_nmi}, {31'd0, exp_nmi});
      if ((k % 6) == 0) begin
        check_val("nmi_disabled", {31'd0, a_nmi}, 32'd1);
      end
      step();
    end

    // Reset in the middle of a wait on dut_r
    irq_req = 1'b1;
    step();
    irq_req = 1'b0;
    #1;
    check_val("r_irq_set", {31'd0, r_irq}, 32'd0);
    addr = 16'h0400;
    step();
    step();
    step();
    check_val("r_mid_wait", {31'd0, r_ready}, 32'd0);
    reset = 1'b1;
    step();
    check_val("r_rst_ready", {31'd0, r_ready}, 32'd1);
    check_val("r_rst_nmi", {31'd0, r_nmi}, 32'd1);
    check_val("r_rst_irq", {31'd0, r_irq}, 32'd1);
    check_val("r_rst_doe", {31'd0, r_doe}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
